dense_layer_ctrl: RTL

Sequencer for `dense_layer_fp`: accepts input chunks from upstream with a valid/ready handshake and drives the weight-memory read address. It aligns each chunk with its weight word and drives the datapath's `vld_in`/`data_in`. It captures the datapath result burst into a one-entry output register with valid/ready handoff, and stalls the last beat of a frame when that result could not be stored.

---
 rtl/dense_pkg.sv | 25 ++
 rtl/pipe_delay.sv | 40 ++++
 rtl/dense_layer_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense layer sequencer and its datapath.
package dense_pkg;

    // Default datapath geometry; the chunk/result types follow it.
    localparam int DP_INPUT_SIZE  = 4;
    localparam int DP_BW          = 16;
    localparam int DP_OUTPUT_SIZE = 128;

    // Width of the beat counter / weight address; never narrower than one bit.
    function automatic int LOG2_CYC(input int num_cyc);
        return (num_cyc > 1) ? $clog2(num_cyc) : 1;
    endfunction

    // One input chunk and one full result word as seen by dense_layer_fp.
    typedef logic [DP_INPUT_SIZE-1:0][DP_BW-1:0]  chunk_t;
    typedef logic [DP_OUTPUT_SIZE-1:0][DP_BW-1:0] result_t;

    // Position of the sequencer within a frame.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pipe_delay.sv
// Valid + data shift register used to line input chunks up with the
// weight memory read latency. All stages reset to zero.
module pipe_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    input  logic [W-1:0] data_in,
    output logic         vld_out,
    output logic [W-1:0] data_out,
    output logic         any_vld
);

    logic [DEPTH-1:0] vld_sr;
    logic [W-1:0]     data_sr [DEPTH];

    // Shift valid and data one stage per cycle; there is no stall path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_sr[i] <= '0;
            end
        end else begin
            vld_sr[0]  <= vld_in;
            data_sr[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                data_sr[i] <= data_sr[i-1];
            end
        end
    end

    assign vld_out  = vld_sr[DEPTH-1];
    assign data_out = data_sr[DEPTH-1];
    assign any_vld  = |vld_sr;

endmodule

// File: rtl/dense_layer_ctrl.sv
// Sequencer for dense_layer_fp: accepts chunks, addresses the weight
// memory by beat index, delays chunks to meet the weight word, and holds
// the datapath result in a one-entry output register.
module dense_layer_ctrl
    import dense_pkg::*;
#(
    parameter int INPUT_SIZE  = 4,
    parameter int NUM_CYC     = 512,
    parameter int BW          = 16,
    parameter int OUTPUT_SIZE = 128,
    parameter int W_LAT       = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [INPUT_SIZE*BW-1:0]      in_data,
    output logic                          w_rd_en,
    output logic [LOG2_CYC(NUM_CYC)-1:0]  w_addr,
    output logic                          dp_vld_in,
    output logic [INPUT_SIZE*BW-1:0]      dp_data_in,
    input  logic                          dp_vld_out,
    input  logic [OUTPUT_SIZE*BW-1:0]     dp_data_out,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [OUTPUT_SIZE*BW-1:0]     out_data,
    output logic                          busy,
    output logic                          err
);

    localparam int            AW        = LOG2_CYC(NUM_CYC);
    localparam logic [AW-1:0] LAST_BEAT = AW'(NUM_CYC - 1);

    seq_state_t    state;
    logic [AW-1:0] beat;
    logic [AW-1:0] beat_nxt;
    logic          pend;
    logic          res_full;
    logic          accept;
    logic          capture;
    logic          drain;
    logic          line_busy;

    // The last beat of a frame may only go once the previous result is gone,
    // so a finished frame always has an empty register to land in.
    assign in_rdy   = (state != ST_LAST) || (!pend && !res_full);
    assign accept   = in_vld && in_rdy;
    assign beat_nxt = beat + AW'(1);

    assign w_rd_en  = accept;
    assign w_addr   = beat;

    assign capture  = dp_vld_out && !res_full;
    assign drain    = res_full && out_rdy;

    assign out_vld  = res_full;
    assign busy     = (beat != '0) || pend || res_full || line_busy;

    // Beat counter and frame position, advanced only on accepted chunks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE, ST_RUN: begin
                    beat  <= beat_nxt;
                    state <= (beat_nxt == LAST_BEAT) ? ST_LAST : ST_RUN;
                end
                ST_LAST: begin
                    beat  <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    beat  <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result tracking: pending after the last beat, held until drained,
    // and a sticky error for results nobody asked for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            res_full <= 1'b0;
            err      <= 1'b0;
            out_data <= '0;
        end else begin
            if (accept && state == ST_LAST) begin
                pend <= 1'b1;
            end else if (dp_vld_out) begin
                pend <= 1'b0;
            end

            if (capture) begin
                out_data <= dp_data_out;
                res_full <= 1'b1;
            end else if (drain) begin
                res_full <= 1'b0;
            end

            if (dp_vld_out && !pend) begin
                err <= 1'b1;
            end
        end
    end

    pipe_delay #(
        .DEPTH (W_LAT),
        .W     (INPUT_SIZE*BW)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (accept),
        .data_in  (in_data),
        .vld_out  (dp_vld_in),
        .data_out (dp_data_in),
        .any_vld  (line_busy)
    );

endmodule
